// File: rtl/fifo_serializer.sv
// fifo_serializer: pops one word at a time from a FIFO and sends it as an idle-high serial frame
// (start bit, LSB-first data, stop bit). Define FIFO_SERIALIZER_PARITY_EN to add an even-parity bit.
module fifo_serializer #(
  parameter int DATO_WIDTH = 3,
  parameter int BAUD_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empy,
  input  logic [DATO_WIDTH-1:0] datin,
  output logic                  rd,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int             BCW        = $clog2(DATO_WIDTH + 1);
  localparam logic [7:0]     BAUD_LAST  = 8'(BAUD_DIV - 1);
  localparam logic [7:0]     BAUD_PEN   = 8'((BAUD_DIV > 1) ? BAUD_DIV - 2 : 0);
  localparam logic [BCW-1:0] BIT_LAST   = BCW'(DATO_WIDTH - 1);
  localparam logic [BCW-1:0] BIT_ONE    = BCW'(1);
  localparam bit             SHORT_STOP = (BAUD_DIV == 1);

  typedef enum logic [2:0] {
    IDLE,
    RD,
    CAP,
    START,
    DATA,
`ifdef FIFO_SERIALIZER_PARITY_EN
    PAR,
`endif
    STOP
  } state_e;

  state_e                state_q;
  logic [DATO_WIDTH-1:0] shift_q;
  logic [DATO_WIDTH-1:0] shift_d;
  logic [BCW-1:0]        bitCnt_q;
  logic [7:0]            baudCnt_q;
  logic                  rd_q;
  logic                  tx_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  baudLast;
`ifdef FIFO_SERIALIZER_PARITY_EN
  logic                  par_q;
`endif

  assign shift_d  = shift_q >> 1;
  assign baudLast = (baudCnt_q == BAUD_LAST);

  // Outputs are registered, so each transition loads the values the next state must present;
  // done is raised one cycle early so it lands on the final STOP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bitCnt_q  <= '0;
      baudCnt_q <= '0;
      rd_q      <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef FIFO_SERIALIZER_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      rd_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (!empy) begin
            rd_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= RD;
          end
        end
        RD: state_q <= CAP;
        CAP: begin
          shift_q   <= datin;
`ifdef FIFO_SERIALIZER_PARITY_EN
          par_q     <= ^datin;
`endif
          baudCnt_q <= '0;
          tx_q      <= 1'b0;
          state_q   <= START;
        end
        START: begin
          if (baudLast) begin
            baudCnt_q <= '0;
            bitCnt_q  <= '0;
            tx_q      <= shift_q[0];
            state_q   <= DATA;
          end else begin
            baudCnt_q <= baudCnt_q + 8'd1;
          end
        end
        DATA: begin
          if (baudLast) begin
            baudCnt_q <= '0;
            if (bitCnt_q == BIT_LAST) begin
`ifdef FIFO_SERIALIZER_PARITY_EN
              tx_q    <= par_q;
              state_q <= PAR;
`else
              tx_q    <= 1'b1;
              done_q  <= SHORT_STOP;
              state_q <= STOP;
`endif
            end else begin
              shift_q  <= shift_d;
              bitCnt_q <= bitCnt_q + BIT_ONE;
              tx_q     <= shift_d[0];
            end
          end else begin
            baudCnt_q <= baudCnt_q + 8'd1;
          end
        end
`ifdef FIFO_SERIALIZER_PARITY_EN
        PAR: begin
          if (baudLast) begin
            baudCnt_q <= '0;
            tx_q      <= 1'b1;
            done_q    <= SHORT_STOP;
            state_q   <= STOP;
          end else begin
            baudCnt_q <= baudCnt_q + 8'd1;
          end
        end
`endif
        STOP: begin
          if (baudLast) begin
            baudCnt_q <= '0;
            busy_q    <= 1'b0;
            state_q   <= IDLE;
          end else begin
            baudCnt_q <= baudCnt_q + 8'd1;
            done_q    <= (baudCnt_q == BAUD_PEN);
          end
        end
        default: begin
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rd   = rd_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// tb_fifo_serializer: directed bench with a per-cycle {done, tx} scoreboard, one DUT at BAUD_DIV=4
// and a second at BAUD_DIV=1 for the single-cycle-bit case.
module tb_fifo_serializer;

  localparam int W = 3;
  localparam int B = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         empy, empy1;
  logic [W-1:0] datin, datin1;
  logic         rd, tx, busy, done;
  logic         rd1, tx1, busy1, done1;

  int checks   = 0;
  int failures = 0;
  int rdPulses = 0;

  logic [1:0] expQ[$];

  always #5 clk = ~clk;

  fifo_serializer #(.DATO_WIDTH(W), .BAUD_DIV(B)) dut (
    .clk(clk), .rst(rst), .empy(empy), .datin(datin),
    .rd(rd), .tx(tx), .busy(busy), .done(done)
  );

  fifo_serializer #(.DATO_WIDTH(W), .BAUD_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .empy(empy1), .datin(datin1),
    .rd(rd1), .tx(tx1), .busy(busy1), .done(done1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rd === 1'b1) rdPulses++;
  endtask

  task automatic sampleOut(input int sel, output logic txV, output logic doneV,
                           output logic rdV, output logic busyV);
    txV   = (sel != 0) ? tx1   : tx;
    doneV = (sel != 0) ? done1 : done;
    rdV   = (sel != 0) ? rd1   : rd;
    busyV = (sel != 0) ? busy1 : busy;
  endtask

  task automatic setInputs(input int sel, input logic e, input logic [W-1:0] d);
    if (sel != 0) begin
      empy1  = e;
      datin1 = d;
    end else begin
      empy  = e;
      datin = d;
    end
  endtask

  // Expected line level for every cycle of a frame, with done flagged on the very last one.
  task automatic pushFrame(input logic [W-1:0] word, input int baud);
    logic bq[$];
    bq.push_back(1'b0);
    for (int i = 0; i < W; i++) bq.push_back(word[i]);
`ifdef FIFO_SERIALIZER_PARITY_EN
    bq.push_back(^word);
`endif
    bq.push_back(1'b1);
    for (int k = 0; k < bq.size(); k++)
      for (int c = 0; c < baud; c++)
        expQ.push_back({(k == bq.size() - 1) && (c == baud - 1), bq[k]});
  endtask

  task automatic runCycles(input int sel, input int n);
    logic [1:0] e;
    logic txV, doneV, rdV, busyV;
    for (int i = 0; i < n; i++) begin
      tick();
      if (expQ.size() == 0) break;
      e = expQ.pop_front();
      sampleOut(sel, txV, doneV, rdV, busyV);
      checkOutput("frame_tx", txV, e[0]);
      checkOutput("frame_done", doneV, e[1]);
      checkOutput("frame_busy", busyV, 1);
      checkOutput("frame_rd", rdV, 0);
    end
  endtask

  // Drives one word through IDLE->RD->CAP and queues its expected frame.
  task automatic applyStimulus(input int sel, input logic [W-1:0] word);
    logic txV, doneV, rdV, busyV;
    setInputs(sel, 1'b0, word);
    tick();
    sampleOut(sel, txV, doneV, rdV, busyV);
    checkOutput("fetch_rd", rdV, 1);
    checkOutput("fetch_busy", busyV, 1);
    checkOutput("fetch_tx", txV, 1);
    setInputs(sel, 1'b1, word);
    tick();
    sampleOut(sel, txV, doneV, rdV, busyV);
    checkOutput("cap_rd", rdV, 0);
    checkOutput("cap_tx", txV, 1);
    checkOutput("cap_busy", busyV, 1);
    pushFrame(word, (sel != 0) ? 1 : B);
  endtask

  task automatic checkIdle(input int sel, input string tag);
    logic txV, doneV, rdV, busyV;
    sampleOut(sel, txV, doneV, rdV, busyV);
    checkOutput({tag, "_tx"}, txV, 1);
    checkOutput({tag, "_rd"}, rdV, 0);
    checkOutput({tag, "_busy"}, busyV, 0);
    checkOutput({tag, "_done"}, doneV, 0);
  endtask

  task automatic sendWord(input int sel, input logic [W-1:0] word);
    applyStimulus(sel, word);
    runCycles(sel, 1);
    setInputs(sel, 1'b1, ~word);
    runCycles(sel, expQ.size());
    tick();
    checkIdle(sel, "post_frame");
  endtask

  initial begin
    rst    = 1'b1;
    empy   = 1'b1;
    empy1  = 1'b1;
    datin  = '0;
    datin1 = '0;

    tick();
    tick();
    checkIdle(0, "reset");
    checkIdle(1, "reset1");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checkIdle(0, "idle_empty");
    end

    sendWord(0, 3'b101);
    sendWord(0, 3'b100);

    // Back-to-back words with the FIFO never running empty.
    rdPulses = 0;
    setInputs(0, 1'b0, 3'b011);
    tick();
    checkOutput("b2b_rd1", rd, 1);
    tick();
    checkOutput("b2b_cap_tx", tx, 1);
    pushFrame(3'b011, B);
    runCycles(0, 1);
    setInputs(0, 1'b0, 3'b110);
    runCycles(0, expQ.size());
    tick();
    checkOutput("gap_idle_tx", tx, 1);
    checkOutput("gap_idle_busy", busy, 0);
    tick();
    checkOutput("gap_rd_tx", tx, 1);
    checkOutput("gap_rd", rd, 1);
    setInputs(0, 1'b1, 3'b110);
    tick();
    checkOutput("gap_cap_tx", tx, 1);
    pushFrame(3'b110, B);
    runCycles(0, expQ.size());
    tick();
    checkIdle(0, "b2b_end");
    checkOutput("b2b_rd_pulses", rdPulses, 2);

    // Abort in the middle of data bit 1.
    applyStimulus(0, 3'b010);
    runCycles(0, 2 * B + 1);
    rst = 1'b1;
    tick();
    checkIdle(0, "abort");
    rst = 1'b0;
    expQ.delete();
    rdPulses = 0;
    for (int i = 0; i < 3 * B; i++) begin
      tick();
      checkOutput("abort_no_done", done, 0);
      checkOutput("abort_tx", tx, 1);
    end
    checkOutput("abort_no_rd", rdPulses, 0);
    sendWord(0, 3'b110);

    // Reset during the RD cycle.
    setInputs(0, 1'b0, 3'b101);
    tick();
    checkOutput("rdrst_rd", rd, 1);
    rst = 1'b1;
    empy = 1'b1;
    tick();
    checkIdle(0, "rdrst");
    rst = 1'b0;
    tick();
    checkIdle(0, "rdrst_after");

    sendWord(1, 3'b111);
    sendWord(1, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_serializer.md
FIFO_SERIALIZER -- requirements
Module: fifo_serializer

Interface
REQ-001 Parameter DATO_WIDTH, default 3, SHALL set the width of the FIFO data word consumed.
REQ-002 Parameter BAUD_DIV, default 4, range 1..255, SHALL set the clk cycles per serial bit.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 empy  input  1  FIFO empty flag, high means no word available.
REQ-006 datin  input  DATO_WIDTH  FIFO read data (FIFO datout).
REQ-007 rd  output  1  one-cycle read strobe, wired to FIFO rclk.
REQ-008 tx  output  1  serial line; idle-high, LSB-first framing.
REQ-009 busy  output  1  high whenever a word is being fetched or sent.
REQ-010 done  output  1  one-cycle pulse at frame completion.

Function
REQ-011 States: IDLE, RD, CAP, START, DATA, PAR, STOP; one-hot or binary encoding is free.
REQ-012 IDLE SHALL go to RD when empy=0 at a clk edge, else stay in IDLE.
REQ-013 rd SHALL be high for exactly the single cycle spent in RD, and low in every other state.
REQ-014 RD SHALL always go to CAP; CAP SHALL latch datin into a DATO_WIDTH shift register and go to START.
REQ-015 START SHALL drive tx=0 for BAUD_DIV cycles.
REQ-016 DATA SHALL shift out DATO_WIDTH bits, LSB first, with each bit held for BAUD_DIV cycles.
REQ-017 A bit counter SHALL be sized ceil(log2(DATO_WIDTH+1)) bits and SHALL clear on entry to DATA.
REQ-018 The baud counter SHALL be 8 bits, count 0..BAUD_DIV-1, and reload to 0 at every bit boundary and state change.
REQ-019 STOP SHALL drive tx=1 for BAUD_DIV cycles; done SHALL be high on the last STOP cycle.
REQ-020 After that last STOP cycle, the state SHALL return to IDLE.
REQ-021 Frame length SHALL be (DATO_WIDTH+2)*BAUD_DIV cycles measured from START entry, plus BAUD_DIV when PAR is active.
REQ-022 Back-to-back words: with empy=0 throughout, START of the next frame SHALL begin exactly 3 cycles (IDLE, RD, CAP) after the last STOP cycle.
REQ-023 empy changes outside IDLE SHALL be ignored.
REQ-024 datin SHALL be sampled only in CAP.
REQ-025 busy SHALL be low only in IDLE.
REQ-026 tx SHALL be 1 in IDLE, RD and CAP.
REQ-027 BAUD_DIV=1 SHALL yield one cycle per bit, with no extra cycles.

Reset
REQ-028 rst=1 at a clk edge SHALL force state=IDLE, tx=1, rd=0, busy=0, done=0, and clear the shift register and both counters.
REQ-029 rst asserted mid-frame SHALL abort the frame immediately; the popped word is discarded and not retransmitted.
REQ-030 rst asserted in the RD cycle SHALL still let that cycle's rd pulse stand, and SHALL return to IDLE on the next edge.

Configuration
REQ-031 Macro FIFO_SERIALIZER_PARITY_EN defined: state PAR SHALL sit between DATA and STOP.
REQ-032 In PAR, tx SHALL equal the XOR of the latched word (even parity) for BAUD_DIV cycles.
REQ-033 Macro undefined: PAR and its logic SHALL not be compiled, and DATA SHALL go directly to STOP.

Verification
REQ-034 rst held 2 cycles, empy=1 -> tx=1, rd=0, busy=0, done=0 indefinitely.
REQ-035 DATO_WIDTH=3, BAUD_DIV=4, no parity, empy falls, datin=3'b101 -> rd pulse 1 cycle, then tx 0,1,0,1,1 each 4 cycles (20 cycles), with done on cycle 20.
REQ-036 Parity enabled, datin=3'b100 -> tx 0,0,0,1,1(parity),1(stop), each 4 cycles, 24-cycle frame.
REQ-037 empy=0 for two words 3'b011, 3'b110 -> two frames with exactly 3 tx-high cycles between STOP end and second START, and exactly two rd pulses.
REQ-038 rst pulsed in DATA bit 1 -> tx=1 next cycle, state IDLE, no done pulse, and the next word fetched is a fresh rd.
REQ-039 BAUD_DIV=1, datin=3'b111 -> 5-cycle frame 0,1,1,1,1 with done on cycle 5.
